// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared encodings and slice sizing for the add/sub datapath blocks
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits handled by each pipeline slice; callers guarantee width % stages == 0.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/rca_slice.sv
// rtl/rca_slice.sv - combinational ripple-carry adder slice built from full_adder cells
module rca_slice #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (carry[i]),
      .s_o (sum[i]),
      .c_o (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - WIDTH-bit add/sub split into STAGES registered carry-chain slices
// Global-stall pipeline: every stage advances together when the output slot is free.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic             v_q       [STAGES];
  logic             v_d       [STAGES];
  logic             carry_q   [STAGES];
  logic             carry_d   [STAGES];
  logic [WIDTH-1:0] skew_a_q  [STAGES];
  logic [WIDTH-1:0] skew_a_d  [STAGES];
  logic [WIDTH-1:0] skew_b_q  [STAGES];
  logic [WIDTH-1:0] skew_b_d  [STAGES];
  logic [WIDTH-1:0] sum_q     [STAGES];
  logic [WIDTH-1:0] sum_d     [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  logic [CHUNK-1:0] sl_a      [STAGES];
  logic [CHUNK-1:0] sl_b      [STAGES];
  logic             sl_cin    [STAGES];
  logic [CHUNK-1:0] sl_sum    [STAGES];
  logic             sl_cout   [STAGES];

  assign b_eff    = (sub == OP_SUB) ? ~b : b;
  assign c0       = (sub == OP_SUB) ? 1'b1 : cin;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Skew registers hold the not-yet-added operand bits right-justified, so each
  // stage always consumes the low CHUNK bits of its predecessor's skew register.
  always_comb begin
    sl_a[0]   = a[CHUNK-1:0];
    sl_b[0]   = b_eff[CHUNK-1:0];
    sl_cin[0] = c0;
    for (int k = 1; k < STAGES; k++) begin
      sl_a[k]   = skew_a_q[k-1][CHUNK-1:0];
      sl_b[k]   = skew_b_q[k-1][CHUNK-1:0];
      sl_cin[k] = carry_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    rca_slice #(
      .WIDTH (CHUNK)
    ) u_slice (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .cin  (sl_cin[k]),
      .sum  (sl_sum[k]),
      .cout (sl_cout[k])
    );
  end

  // Deskew: each new slice sum enters at the top and older slices shift down,
  // so after the last stage the chunks sit in their natural bit positions.
  always_comb begin
    v_d[0]      = in_valid;
    carry_d[0]  = sl_cout[0];
    skew_a_d[0] = a >> CHUNK;
    skew_b_d[0] = b_eff >> CHUNK;
    sum_d[0]    = WIDTH'(sl_sum[0]) << (WIDTH - CHUNK);
    for (int k = 1; k < STAGES; k++) begin
      v_d[k]      = v_q[k-1];
      carry_d[k]  = sl_cout[k];
      skew_a_d[k] = skew_a_q[k-1] >> CHUNK;
      skew_b_d[k] = skew_b_q[k-1] >> CHUNK;
      sum_d[k]    = (sum_q[k-1] >> CHUNK) | (WIDTH'(sl_sum[k]) << (WIDTH - CHUNK));
    end
    ovf_d = (sl_a[STAGES-1][CHUNK-1] == sl_b[STAGES-1][CHUNK-1]) &&
            (sl_sum[STAGES-1][CHUNK-1] != sl_a[STAGES-1][CHUNK-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]      <= 1'b0;
        carry_q[k]  <= 1'b0;
        skew_a_q[k] <= '0;
        skew_b_q[k] <= '0;
        sum_q[k]    <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]      <= v_d[k];
        carry_q[k]  <= carry_d[k];
        skew_a_q[k] <= skew_a_d[k];
        skew_b_q[k] <= skew_b_d[k];
        sum_q[k]    <= sum_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign result    = {carry_q[STAGES-1], sum_q[STAGES-1]};
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub across four parameter sets
module tb_pipelined_addsub;

  localparam int NI = 4;
  localparam int WS [NI] = '{16, 8, 8, 32};
  localparam int SS [NI] = '{4, 1, 8, 4};

  logic        clk;
  logic        rst;
  logic        iv   [NI];
  logic        orr  [NI];
  logic        cn   [NI];
  logic        sb   [NI];
  logic [31:0] av   [NI];
  logic [31:0] bv   [NI];
  logic        ir   [NI];
  logic        ovld [NI];
  logic        ovw  [NI];
  logic [32:0] rs   [NI];

  int checks;
  int errors;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = WS[g];
    logic [W:0] r;
    pipelined_addsub #(
      .WIDTH  (W),
      .STAGES (SS[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .a         (av[g][W-1:0]),
      .b         (bv[g][W-1:0]),
      .cin       (cn[g]),
      .sub       (sb[g]),
      .out_valid (ovld[g]),
      .out_ready (orr[g]),
      .result    (r),
      .ovf       (ovw[g])
    );
    assign rs[g] = 33'(r);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; returns {ovf, result}.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    longint m, ua, ub, sa, sbv, tot, sv, one;
    logic [63:0] t;
    m   = longint'(1) << w;
    ua  = longint'({32'd0, a}) & (m - 1);
    ub  = longint'({32'd0, b}) & (m - 1);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    one = c ? 1 : 0;
    if (s) begin
      tot = (ua - ub) & (m - 1);
      if (ua >= ub) tot = tot + m;
      sv = sa - sbv;
    end else begin
      tot = ua + ub + one;
      sv  = sa + sbv + one;
    end
    t = tot;
    return {(sv >= m / 2) || (sv < -(m / 2)), t[32:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      2:       return 32'h8000_8080;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b1; orr[i] = 1'b1; cn[i] = 1'b1; sb[i] = 1'b0;
      av[i] = 32'hFFFF_FFFF; bv[i] = 32'h1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) iv[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (ovld[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", i, ovld[i]); end
      checks++;
      if (rs[i] !== 33'd0) begin errors++; $display("FAIL reset_result[%0d] got=%h exp=0", i, rs[i]); end
      checks++;
      if (ovw[i] !== 1'b0) begin errors++; $display("FAIL reset_ovf[%0d] got=%b exp=0", i, ovw[i]); end
      checks++;
      if (ir[i] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", i, ir[i]); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [4] = '{32'hFFFF, 32'h7FFF, 32'h0000, 32'h8000};
    logic [31:0] tb [4] = '{32'h0001, 32'h0001, 32'h0001, 32'h0001};
    logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [32:0] tr [4] = '{33'h1_0000, 33'h0_8000, 33'h0_FFFF, 33'h1_7FFF};
    logic        to [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      iv[0] = 1'b1; av[0] = ta[v]; bv[0] = tb[v]; cn[0] = 1'b0; sb[0] = ts[v]; orr[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (ir[0] !== 1'b1) begin errors++; $display("FAIL dir_in_ready[%0d] got=%b exp=1", v, ir[0]); end
      @(posedge clk); #1;
      iv[0] = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        if (c > 1) @(negedge clk);
        else @(negedge clk);
        checks++;
        if (ovld[0] !== (c == 4)) begin
          errors++; $display("FAIL dir_latency[%0d] cycle %0d got=%b exp=%b", v, c, ovld[0], c == 4);
        end
      end
      checks++;
      if (rs[0] !== tr[v]) begin errors++; $display("FAIL dir_result[%0d] got=%h exp=%h", v, rs[0], tr[v]); end
      checks++;
      if (ovw[0] !== to[v]) begin errors++; $display("FAIL dir_ovf[%0d] got=%b exp=%b", v, ovw[0], to[v]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_v [8];
    @(posedge clk); #1;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      orr[0] = 1'b1;
      if (c < 8) begin
        iv[0] = 1'b1; av[0] = rand_operand(); bv[0] = rand_operand();
        cn[0] = $urandom_range(0, 1); sb[0] = $urandom_range(0, 1);
        if (c == 3) begin cn[0] = 1'b1; sb[0] = 1'b1; end
        if (c == 5) begin cn[0] = 1'b1; sb[0] = 1'b0; end
        exp_v[c] = model(16, av[0], bv[0], cn[0], sb[0]);
      end else begin
        iv[0] = 1'b0;
      end
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (ir[0] !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cycle %0d got=%b exp=1", c, ir[0]); end
      end
      checks++;
      if (ovld[0] !== (c >= 4 && c <= 11)) begin
        errors++; $display("FAIL b2b_out_valid cycle %0d got=%b exp=%b", c, ovld[0], c >= 4 && c <= 11);
      end
      if (c >= 4 && c <= 11) begin
        checks++;
        if ({ovw[0], rs[0]} !== exp_v[c-4]) begin
          errors++; $display("FAIL b2b_result[%0d] got=%h exp=%h", c - 4, {ovw[0], rs[0]}, exp_v[c-4]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic        tc [6];
    logic        ts [6];
    logic [33:0] exp_q [$];
    logic [33:0] held;
    int          sent;
    int          recv;
    for (int i = 0; i < 6; i++) begin
      ta[i] = rand_operand(); tb[i] = rand_operand();
      tc[i] = $urandom_range(0, 1); ts[i] = $urandom_range(0, 1);
    end
    sent = 0; recv = 0; held = '0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      @(posedge clk); #1;
      orr[0] = !(c >= 4 && c <= 6);
      if (sent < 6) begin
        iv[0] = 1'b1; av[0] = ta[sent]; bv[0] = tb[sent]; cn[0] = tc[sent]; sb[0] = ts[sent];
      end else begin
        iv[0] = 1'b0;
      end
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        checks++;
        if (ovld[0] !== 1'b1 || ir[0] !== 1'b0) begin
          errors++; $display("FAIL stall_handshake cycle %0d got valid=%b ready=%b exp valid=1 ready=0", c, ovld[0], ir[0]);
        end
      end
      if (c == 4) held = {ovw[0], rs[0]};
      if (c == 5 || c == 6) begin
        checks++;
        if ({ovw[0], rs[0]} !== held) begin
          errors++; $display("FAIL stall_stable cycle %0d got=%h exp=%h", c, {ovw[0], rs[0]}, held);
        end
      end
      if (iv[0] && ir[0]) begin
        exp_q.push_back(model(16, ta[sent], tb[sent], tc[sent], ts[sent]));
        sent++;
      end
      if (c == 6) begin
        checks++;
        if (sent != 4) begin errors++; $display("FAIL stall_accepted got=%0d exp=4", sent); end
      end
      if (ovld[0] && orr[0]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_extra_result got=%h exp=none", {ovw[0], rs[0]});
        end else begin
          if ({ovw[0], rs[0]} !== exp_q[0]) begin
            errors++; $display("FAIL stall_result[%0d] got=%h exp=%h", recv, {ovw[0], rs[0]}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        recv++;
      end
    end
    checks++;
    if (recv != 6 || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_count got=%0d exp=6", recv);
    end
  endtask

  task automatic test_reset_midflight();
    logic [33:0] e;
    int          seen;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      orr[0] = 1'b1; iv[0] = 1'b1; av[0] = rand_operand(); bv[0] = rand_operand();
      cn[0] = 1'b0; sb[0] = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1; iv[0] = 1'b1; av[0] = 32'h1234; bv[0] = 32'h4321;
    @(posedge clk); #1;
    rst = 1'b0; iv[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ovld[0] !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b exp=0", ovld[0]); end
    checks++;
    if (rs[0] !== 33'd0) begin errors++; $display("FAIL midreset_result got=%h exp=0", rs[0]); end
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (ovld[0] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_ghost got=%0d exp=0", seen); end
    @(posedge clk); #1;
    iv[0] = 1'b1; av[0] = 32'hA5A5; bv[0] = 32'h5A5B; cn[0] = 1'b1; sb[0] = 1'b1;
    e = model(16, av[0], bv[0], cn[0], sb[0]);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (ovld[0] !== (c == 4)) begin
        errors++; $display("FAIL midreset_latency cycle %0d got=%b exp=%b", c, ovld[0], c == 4);
      end
    end
    checks++;
    if ({ovw[0], rs[0]} !== e) begin errors++; $display("FAIL midreset_result_after got=%h exp=%h", {ovw[0], rs[0]}, e); end
  endtask

  task automatic test_sweep(input int idx);
    logic [33:0] exp_q [$];
    logic [33:0] held;
    logic        stalled;
    logic        holding;
    int          sent;
    int          recv;
    int          cyc;
    sent = 0; recv = 0; cyc = 0; stalled = 1'b0; holding = 1'b0; held = '0;
    while (recv < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      orr[idx] = ($urandom_range(0, 3) != 0);
      if (!holding) begin
        iv[idx] = (sent < 1000) && ($urandom_range(0, 4) != 0);
        av[idx] = rand_operand(); bv[idx] = rand_operand();
        cn[idx] = $urandom_range(0, 1); sb[idx] = $urandom_range(0, 1);
      end
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (ovld[idx] !== 1'b1 || {ovw[idx], rs[idx]} !== held) begin
          errors++; $display("FAIL sweep%0d_stall_stable got=%h exp=%h", idx, {ovw[idx], rs[idx]}, held);
        end
      end
      if (ovld[idx] && !orr[idx]) begin
        checks++;
        if (ir[idx] !== 1'b0) begin errors++; $display("FAIL sweep%0d_stall_ready got=%b exp=0", idx, ir[idx]); end
      end
      if (iv[idx] && ir[idx]) begin
        exp_q.push_back(model(WS[idx], av[idx], bv[idx], cn[idx], sb[idx]));
        sent++;
        holding = 1'b0;
      end else begin
        holding = iv[idx];
      end
      if (ovld[idx] && orr[idx]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sweep%0d_extra_result got=%h exp=none", idx, {ovw[idx], rs[idx]});
        end else begin
          if ({ovw[idx], rs[idx]} !== exp_q[0]) begin
            errors++; $display("FAIL sweep%0d_result[%0d] got=%h exp=%h", idx, recv, {ovw[idx], rs[idx]}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        recv++;
      end
      stalled = ovld[idx] && !orr[idx];
      held    = {ovw[idx], rs[idx]};
    end
    iv[idx] = 1'b0;
    checks++;
    if (recv != 1000) begin errors++; $display("FAIL sweep%0d_count got=%0d exp=1000", idx, recv); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_sweep(1);
    test_sweep(2);
    test_sweep(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined ripple-carry adder/subtractor. It splits a WIDTH-bit add or subtract into STAGES equal carry-chain slices, one slice per clock. It accepts one operation per cycle under a valid/ready handshake and returns the (WIDTH+1)-bit result plus a signed-overflow flag after STAGES cycles. It is the datapath successor to the fixed 4-bit combinational ripple adder and is used wherever wide operands would otherwise break timing.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of STAGES (elaboration error otherwise).
- STAGES, 4, number of pipeline stages; 1 ≤ STAGES ≤ WIDTH.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A−B (computed as A+~B+1; cin ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH+1  {carry_out, sum}; for sub, carry_out=1 means no borrow.
- ovf  output  1  signed overflow of the WIDTH-bit sum.

## Operation
- CHUNK = WIDTH/STAGES. Stage k (0..STAGES−1) adds bits [k·CHUNK +: CHUNK] of A and B' using the carry registered by stage k−1. Stage 0 uses c0 = sub ? 1 : cin.
- B' = sub ? ~b : b, formed at the input before stage 0.
- Skew registers carry the not-yet-added upper operand bits forward. Deskew registers carry the already-computed lower sum bits forward, so result emerges aligned.
- result[WIDTH] is the carry out of the final slice.
- ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]). It is computed in the last stage, which needs the operand MSBs (already present there via the skew registers).
- Global-stall pipeline: advance = !out_valid || out_ready; in_ready = advance.
- When advance=1, every stage register loads from its predecessor, and stage 0 loads {in_valid, operands}. When advance=0, all stages hold.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Bubbles propagate as valid=0 slots; no compaction is required.
- No FSM. Per-stage valid bits form the only control state.

## Timing
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+STAGES, assuming no stall. Each stall cycle adds exactly one cycle.
- Throughput: one op per cycle when out_ready is held at 1.
- result, ovf and out_valid are all registered outputs. in_ready is combinational from out_valid and out_ready.
- While out_valid && !out_ready: result and ovf are held stable, in_ready=0, and no input is taken.
- Reset: all stage valid bits=0, out_valid=0, result=0, ovf=0, in_ready=1 in the cycle after reset.
- Reset mid-operation: in-flight ops are discarded and none emerge afterwards. Reset dominates in_valid in the same cycle.
- An in_valid pulse with in_ready=0 is not accepted. The source must hold it.
- Wrap-around: the sum is modulo 2^WIDTH, with the overflow bit in result[WIDTH]. Carry must propagate correctly across all slice boundaries within the same op.
- STAGES=1 degenerates to a registered full-width adder with latency 1.

## Structure
- Shared package addsub_pkg holds the OP_ADD/OP_SUB encoding constants (0/1) and the CHUNK derivation function, so sibling datapath blocks reuse them.
- Sub-module rca_slice: combinational CHUNK-bit ripple adder (inputs a, b, cin; outputs sum, cout), built from the team's existing full-adder cell. It is instantiated STAGES times via generate.
- The top level contains only the stage/skew/deskew registers and the handshake logic.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1: a=0xFFFF, b=0x0001, cin=0, sub=0 → after 4 cycles result=0x1_0000, ovf=0 (carry crosses every slice).
- a=0x7FFF, b=0x0001, sub=0 → result=0x0_8000, ovf=1. Then a=0x0000, b=0x0001, sub=1 → result=0x0_FFFF (borrow), ovf=0. Then a=0x8000, b=0x0001, sub=1 → result=0x1_7FFF, ovf=1.
- 8 back-to-back ops accepted on cycles 0..7 → 8 results with out_valid on cycles 4..11, in order, matching a reference model. Includes cin=1 with sub=1 to prove cin is ignored.
- Stall: out_ready=0 for 3 cycles while out_valid=1 → result stable, in_ready=0, held in_valid not consumed. On release, all ops emerge in order with none lost or duplicated.
- Reset with 3 ops in flight → out_valid=0 and result=0 the next cycle, none of the 3 ever emerge, and a new op afterwards completes in 4 cycles.
- Parameter sweep (WIDTH,STAGES) = (8,1), (8,8), (32,4), 1000 random ops each with random out_ready → all results and ovf match the model; no result ever changes while stalled.
